// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared instruction/data memory.
// One transaction in flight; registered strobes and fixed-latency read capture.
module mem_port_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int READ_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT3 = 3'(READ_LAT);

    state_t        state_r;
    logic          last_grant_r;
    logic          owner_r;
    logic          is_write_r;
    logic [2:0]    cnt_r;

    logic          any_req_s;
    logic          pick0_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;

    // Winner selection: a tie goes to the port that was not granted last.
    always_comb begin
        any_req_s = req0 | req1;
        pick0_s   = 1'b0;
        if (req0 && req1) begin
            pick0_s = last_grant_r;
        end else if (req0) begin
            pick0_s = 1'b1;
        end else begin
            pick0_s = 1'b0;
        end
        if (pick0_s) begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end else begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            is_write_r   <= 1'b0;
            cnt_r        <= 3'd0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata        <= {DW{1'b0}};
            busy         <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        gnt0         <= pick0_s;
                        gnt1         <= ~pick0_s;
                        owner_r      <= ~pick0_s;
                        last_grant_r <= ~pick0_s;
                        is_write_r   <= win_we_s;
                        mem_addr     <= win_addr_s;
                        mem_wdata    <= win_wdata_s;
                        mem_read     <= ~win_we_s;
                        mem_write    <= win_we_s;
                        cnt_r        <= win_we_s ? 3'd0 : LAT3;
                        busy         <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Counter reaching zero marks the cycle holding valid read data.
                    if (cnt_r == 3'd0) begin
                        if (!is_write_r) begin
                            rdata <= mem_rdata;
                        end else begin
                            rdata <= rdata;
                        end
                        done0   <= ~owner_r;
                        done1   <= owner_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r - 3'd1;
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
